// File: rtl/mskaes_sb_serial.sv
// mskaes_sb_serial: serialised masked AES SubBytes layer for a d-share datapath.
//
// The 16-byte shared state is latched on the input handshake and pushed through
// NSB masked S-boxes in 16/NSB chunks. Results are collected into an output state
// register, which is presented with a valid/ready handshake.
//
// Parameters:
//   d    number of shares (>= 2)
//   NSB  parallel S-box instances (1, 2, 4, 8 or 16)
//   LAT  S-box latency in cycles, counted from the feed cycle to the collect cycle (>= 2)
//
// Ports:
//   clk, nrst             clock, synchronous active-low reset
//   in_valid / in_ready   input handshake
//   sh_state_in           shared input state (byte i at [8*d*i +: 8*d], bit j shares at [j*d +: d])
//   rnd_bus0/2/3/4        fresh S-box randomness, required every RUN cycle
//   out_valid / out_ready output handshake
//   sh_state_out          shared output state, same layout as sh_state_in
//
// Build option: define MSKAES_SB_CLEAR_EN to wipe the input latch and output register
// on the output handshake and to force sh_state_out to 0 while out_valid is low.
//
// bp_aes_sbox_msk below is a behavioural stand-in with the netlist's ports and latency
// (it is NOT side-channel secure); replace it with the real gadget netlist for silicon.

module bp_aes_sbox_msk #(
  parameter int unsigned d   = 2,
  parameter int unsigned LAT = 4
) (
  input  logic                         clk,
  input  logic [8*d-1:0]               sh_in,
  input  logic [9*(d*(d-1)/2)-1:0]     rnd_bus0,
  input  logic [3*(d*(d-1)/2)-1:0]     rnd_bus2,
  input  logic [4*(d*(d-1)/2)-1:0]     rnd_bus3,
  input  logic [18*(d*(d-1)/2)-1:0]    rnd_bus4,
  output logic [8*d-1:0]               sh_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] b;
    r = 8'h01;
    b = a;
    // a^254 is the field inverse (0 maps to 0)
    for (int i = 1; i < 8; i++) begin
      b = gf_mul(b, b);
      r = gf_mul(r, b);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  logic [7:0]     x;
  logic [7:0]     y;
  logic           acc;
  logic [8*d-1:0] sh_res;
  logic [8*d-1:0] pipe_q [LAT-1];
  logic           unused_rnd;

  assign unused_rnd = ^{rnd_bus0, rnd_bus2, rnd_bus3, rnd_bus4};

  always_comb begin
    x      = '0;
    acc    = 1'b0;
    sh_res = '0;
    for (int j = 0; j < 8; j++) x[j] = ^sh_in[j*d +: d];
    y = aes_sbox(x);
    // Fresh masks for shares 0..d-2, last share completes the value
    for (int j = 0; j < 8; j++) begin
      acc = y[j];
      for (int s = 0; s < int'(d) - 1; s++) begin
        sh_res[j*d+s] = rnd_bus0[8*s+j];
        acc           = acc ^ rnd_bus0[8*s+j];
      end
      sh_res[j*d+d-1] = acc;
    end
  end

  always_ff @(posedge clk) begin
    pipe_q[0] <= sh_res;
    for (int i = 1; i < int'(LAT) - 1; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign sh_out = pipe_q[LAT-2];

endmodule

module mskaes_sb_serial #(
  parameter int unsigned d   = 2,
  parameter int unsigned NSB = 4,
  parameter int unsigned LAT = 4
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [128*d-1:0]               sh_state_in,
  input  logic [NSB*9*(d*(d-1)/2)-1:0]   rnd_bus0,
  input  logic [NSB*3*(d*(d-1)/2)-1:0]   rnd_bus2,
  input  logic [NSB*4*(d*(d-1)/2)-1:0]   rnd_bus3,
  input  logic [NSB*18*(d*(d-1)/2)-1:0]  rnd_bus4,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [128*d-1:0]               sh_state_out
);

  localparam int unsigned HPC2RND = d * (d - 1) / 2;
  localparam int unsigned NCHUNK  = 16 / NSB;
  localparam int unsigned CW      = ($clog2(NCHUNK + 1) > 1) ? $clog2(NCHUNK + 1) : 1;
  localparam int unsigned BW      = 8 * d;
  localparam int unsigned CHW     = NSB * BW;
  localparam logic [CW-1:0] NCHUNK_C = CW'(NCHUNK);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    fc_q, fc_d;
  logic [CW-1:0]    cc_q, cc_d;
  logic [LAT-2:0]   vld_q;
  logic [LAT-1:0]   vld_all;
  logic             feed;
  logic             exit_vld;
  logic [128*d-1:0] in_state_q;
  logic [128*d-1:0] out_state_q;
  logic [CHW-1:0]   sbox_in;
  logic [CHW-1:0]   sbox_out;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

  assign feed     = (state_q == StRun) && (fc_q < NCHUNK_C);
  // Bit 0 is the feed cycle itself; the top bit marks the cycle a chunk leaves the S-boxes.
  assign vld_all  = {vld_q, feed};
  assign exit_vld = vld_all[LAT-1];

  always_comb begin
    sbox_in = '0;
    for (int k = 0; k < int'(NCHUNK); k++) begin
      if (fc_q == CW'(k)) sbox_in = in_state_q[k*CHW +: CHW];
    end
  end

  for (genvar j = 0; j < NSB; j++) begin : g_sbox
    bp_aes_sbox_msk #(
      .d   (d),
      .LAT (LAT)
    ) u_sbox (
      .clk      (clk),
      .sh_in    (sbox_in[j*BW +: BW]),
      .rnd_bus0 (rnd_bus0[j*9*HPC2RND +: 9*HPC2RND]),
      .rnd_bus2 (rnd_bus2[j*3*HPC2RND +: 3*HPC2RND]),
      .rnd_bus3 (rnd_bus3[j*4*HPC2RND +: 4*HPC2RND]),
      .rnd_bus4 (rnd_bus4[j*18*HPC2RND +: 18*HPC2RND]),
      .sh_out   (sbox_out[j*BW +: BW])
    );
  end

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    cc_d    = cc_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StRun;
          fc_d    = '0;
          cc_d    = '0;
        end
      end
      StRun: begin
        if (feed) fc_d = fc_q + 1'b1;
        // Chunks leave the pipeline in feed order, so cc names the exiting chunk
        if (exit_vld) begin
          cc_d = cc_q + 1'b1;
          if (cc_q == NCHUNK_C - 1'b1) state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= StIdle;
      fc_q        <= '0;
      cc_q        <= '0;
      vld_q       <= '0;
      in_state_q  <= '0;
      out_state_q <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      cc_q    <= cc_d;
      vld_q   <= vld_all[LAT-2:0];
      if (in_valid && in_ready) in_state_q <= sh_state_in;
      for (int k = 0; k < int'(NCHUNK); k++) begin
        if (exit_vld && (cc_q == CW'(k))) out_state_q[k*CHW +: CHW] <= sbox_out;
      end
`ifdef MSKAES_SB_CLEAR_EN
      if (out_valid && out_ready) begin
        in_state_q  <= '0;
        out_state_q <= '0;
      end
`endif
    end
  end

`ifdef MSKAES_SB_CLEAR_EN
  assign sh_state_out = out_valid ? out_state_q : '0;
`else
  assign sh_state_out = out_state_q;
`endif

endmodule

// File: tb/tb_mskaes_sb_serial.sv
// Self-checking bench for mskaes_sb_serial: NSB=4 instance against a cycle-level
// transaction model, plus NSB=1/2/8/16 instances against literal AES S-box results.

module tb_mskaes_sb_serial;

  localparam int D   = 2;
  localparam int H   = D * (D - 1) / 2;
  localparam int LAT = 4;
  localparam int NSB = 4;
  localparam int NCH = 16 / NSB;

  localparam logic [127:0] SEQ_EXP = 128'h76ABD7FE2B670130C56F6BF27B777C63;

  logic [2047:0] sbox_flat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  int n_cmp = 0;
  int n_err = 0;
  int gen_done = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] a);
    return sbox_flat[2047 - 8*int'(a) -: 8];
  endfunction

  function automatic logic [127:0] sbox_state(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sb(v[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [128*D-1:0] share(input logic [127:0] v);
    logic [128*D-1:0] r;
    logic acc;
    r = '0;
    for (int i = 0; i < 128; i++) begin
      acc = v[i];
      for (int s = 0; s < D - 1; s++) begin
        r[i*D+s] = 1'($urandom);
        acc = acc ^ r[i*D+s];
      end
      r[i*D+D-1] = acc;
    end
    return r;
  endfunction

  function automatic logic [127:0] recomb(input logic [128*D-1:0] s);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = ^s[i*D +: D];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [1023:0] rand_vec();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- main NSB=4 instance ----------------
  logic                 nrst, in_valid, in_ready, out_valid, out_ready;
  logic [128*D-1:0]     sh_in, sh_out;
  logic [NSB*9*H-1:0]   rnd0;
  logic [NSB*3*H-1:0]   rnd2;
  logic [NSB*4*H-1:0]   rnd3;
  logic [NSB*18*H-1:0]  rnd4;

  mskaes_sb_serial #(
    .d   (D),
    .NSB (NSB),
    .LAT (LAT)
  ) u_dut (
    .clk          (clk),
    .nrst         (nrst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sh_state_in  (sh_in),
    .rnd_bus0     (rnd0),
    .rnd_bus2     (rnd2),
    .rnd_bus3     (rnd3),
    .rnd_bus4     (rnd4),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sh_state_out (sh_out)
  );

  initial begin
    logic [1023:0] rv;
    forever begin
      @(posedge clk);
      #1;
      rv   = rand_vec();
      rnd0 = rv[NSB*9*H-1:0];
      rnd2 = rv[200 +: NSB*3*H];
      rnd3 = rv[300 +: NSB*4*H];
      rnd4 = rv[400 +: NSB*18*H];
    end
  end

  // Transaction model: 0 idle, 1 busy, 2 result held
  int           m_state = 0;
  int           m_wait = 0;
  logic [127:0] m_exp = '0;
  bit           cmp_en = 1'b0;

  always @(posedge clk) begin
    if (!nrst) begin
      m_state <= 0;
      m_wait  <= 0;
      m_exp   <= '0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
          m_state <= 1;
          m_wait  <= NCH + LAT - 1;
          m_exp   <= sbox_state(recomb(sh_in));
        end
        1: if (m_wait == 1) m_state <= 2; else m_wait <= m_wait - 1;
        default: if (out_ready) m_state <= 0;
      endcase
    end
  end

  logic [128*D-1:0] hold_snap;
  bit               prev_done = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready", in_ready, m_state == 0);
      check("out_valid", out_valid, m_state == 2);
      if (m_state == 2) begin
        check("result", recomb(sh_out), m_exp);
        if (prev_done) check("held_stable", sh_out, hold_snap);
        hold_snap = sh_out;
      end
`ifdef MSKAES_SB_CLEAR_EN
      if (m_state != 2) check("out_zero_when_invalid", sh_out, '0);
      if (m_state == 0) check("in_latch_cleared", u_dut.in_state_q, '0);
`else
      if (m_state == 0) check("idle_keeps_result", recomb(sh_out), m_exp);
`endif
      prev_done = (m_state == 2) && !out_ready;
    end
  end

  task automatic run_state(input logic [127:0] v, input int hold, input bit toggle,
                           output int lat, output logic [127:0] res);
    in_valid = 1'b1;
    sh_in    = share(v);
    @(posedge clk);
    #1;
    lat      = 1;
    in_valid = 1'b0;
    sh_in    = share(rand128());
    while (!out_valid && lat < 100) begin
      if (toggle) begin
        in_valid = 1'($urandom);
        sh_in    = share(rand128());
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    if (lat >= 100) check("out_valid_timeout", out_valid, 1'b1);
    res = recomb(sh_out);
    repeat (hold) begin
      check("in_ready_while_held", in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("in_ready_after_out_hs", in_ready, 1'b1);
  endtask

  initial begin
    int           lat;
    logic [127:0] res;
    logic [127:0] v;
    nrst      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sh_in     = '0;
    @(posedge clk);
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_state", sh_out, '0);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // All-zero state: every byte becomes 0x63 at cycle 8
    run_state('0, 0, 1'b0, lat, res);
    check("zero_latency", lat, 8);
    check("zero_result", res, {16{8'h63}});

    // Reset during the cycle chunk 2 is fed (cycle 3)
    in_valid = 1'b1;
    sh_in    = share(rand128());
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    check("midrun_reset_in_ready", in_ready, 1'b1);
    check("midrun_reset_out_valid", out_valid, 1'b0);
    run_state({16{8'h53}}, 0, 1'b0, lat, res);
    check("x53_latency", lat, 8);
    check("x53_result", res, {16{8'hED}});

    // Back-pressure: out_ready low for 5 cycles
    v = rand128();
    run_state(v, 5, 1'b0, lat, res);
    check("hold_result", res, sbox_state(v));

    // Random states with in_valid toggling during RUN
    for (int t = 0; t < 20; t++) begin
      v = rand128();
      run_state(v, $urandom_range(0, 3), 1'b1, lat, res);
      check("rand_latency", lat, NCH + LAT);
      check("rand_result", res, sbox_state(v));
    end

    for (int i = 0; i < 2000 && gen_done < 4; i++) @(posedge clk);
    check("nsb_sweep_done", gen_done, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- NSB sweep instances ----------------
  for (genvar g = 0; g < 4; g++) begin : g_nsb
    localparam int N = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;

    logic               nrst_g, iv, ir, ov, ordy;
    logic [128*D-1:0]   si, so;
    logic [N*9*H-1:0]   r0;
    logic [N*3*H-1:0]   r2;
    logic [N*4*H-1:0]   r3;
    logic [N*18*H-1:0]  r4;

    mskaes_sb_serial #(
      .d   (D),
      .NSB (N),
      .LAT (LAT)
    ) u_dut (
      .clk          (clk),
      .nrst         (nrst_g),
      .in_valid     (iv),
      .in_ready     (ir),
      .sh_state_in  (si),
      .rnd_bus0     (r0),
      .rnd_bus2     (r2),
      .rnd_bus3     (r3),
      .rnd_bus4     (r4),
      .out_valid    (ov),
      .out_ready    (ordy),
      .sh_state_out (so)
    );

    initial begin
      logic [1023:0] rv;
      forever begin
        @(posedge clk);
        #1;
        rv = rand_vec();
        r0 = rv[N*9*H-1:0];
        r2 = rv[200 +: N*3*H];
        r3 = rv[300 +: N*4*H];
        r4 = rv[600 +: N*18*H];
      end
    end

    initial begin
      int           lat;
      logic [127:0] v;
      nrst_g = 1'b0;
      iv     = 1'b0;
      ordy   = 1'b0;
      si     = '0;
      repeat (2) @(posedge clk);
      #1;
      nrst_g = 1'b1;
      for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'(i);
      iv = 1'b1;
      si = share(v);
      @(posedge clk);
      #1;
      iv  = 1'b0;
      lat = 1;
      while (!ov && lat < 100) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("nsb%0d_latency", N), lat, 16 / N + 4);
      check($sformatf("nsb%0d_result", N), recomb(so), SEQ_EXP);
      check($sformatf("nsb%0d_in_ready_done", N), ir, 1'b0);
      ordy = 1'b1;
      @(posedge clk);
      #1;
      ordy = 1'b0;
      check($sformatf("nsb%0d_in_ready_after", N), ir, 1'b1);
      check($sformatf("nsb%0d_out_valid_after", N), ov, 1'b0);
      gen_done++;
    end
  end

endmodule
